// File: rtl/vital_alarm_monitor_if.sv
// Bus between the MAX30100 vital-sign path (master) and the alarm monitor (slave).
// The master drives the raw levels and the operator ack; the slave returns averages and alarms.
interface vital_alarm_monitor_if;
   logic [15:0] heart_rate;
   logic [7:0]  spo2;
   logic        alarm_ack;
   logic [15:0] hr_avg;
   logic [7:0]  spo2_avg;
   logic        avg_valid;
   logic        avg_strobe;
   logic        hr_high_alarm;
   logic        hr_low_alarm;
   logic        spo2_low_alarm;
   logic        alarm_latched;
   logic        sensor_fault;

   modport master (
      output heart_rate, spo2, alarm_ack,
      input  hr_avg, spo2_avg, avg_valid, avg_strobe,
             hr_high_alarm, hr_low_alarm, spo2_low_alarm,
             alarm_latched, sensor_fault
   );

   modport slave (
      input  heart_rate, spo2, alarm_ack,
      output hr_avg, spo2_avg, avg_valid, avg_strobe,
             hr_high_alarm, hr_low_alarm, spo2_low_alarm,
             alarm_latched, sensor_fault
   );
endinterface

// File: rtl/vital_alarm_monitor.sv
// Ticked sampler of heart rate / SpO2 with a 4-deep moving average, persistence-filtered
// threshold alarms, a sticky operator alarm and a no-signal sensor fault.
module vital_alarm_monitor #(
   parameter int unsigned SAMPLE_DIV  = 1000000,
   parameter logic [15:0] HR_HIGH     = 16'd120,
   parameter logic [15:0] HR_LOW      = 16'd40,
   parameter logic [7:0]  SPO2_LOW    = 8'd90,
   parameter int unsigned PERSIST     = 3,
   parameter int unsigned NOSIG_LIMIT = 5
) (
   input  logic                 clk_1MHz,
   input  logic                 rst_n,
   vital_alarm_monitor_if.slave bus
);

   localparam int DIV_W = $clog2(SAMPLE_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
   localparam logic [3:0] PERSIST_C = 4'(PERSIST);
   localparam logic [3:0] NOSIG_C   = 4'(NOSIG_LIMIT);

   localparam logic [1:0] ST_FILL  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   logic [DIV_W-1:0] divCnt_q, divCnt_d;
   logic             tick;
   logic             noSignal;

   logic [1:0]       state_q, state_d;
   logic [2:0]       fill_q, fill_d;
   logic [3:0]       noSig_q, noSig_d;
   logic [3:0][15:0] hrWin_q, hrWin_d;
   logic [3:0][7:0]  spWin_q, spWin_d;
   logic             eval_q, eval_d;
   logic             enterFault_q, enterFault_d;
   logic             leaveFault_q, leaveFault_d;

   logic [17:0]      hrSum;
   logic [9:0]       spSum;
   logic [15:0]      hrAvgNow;
   logic [7:0]       spAvgNow;
   logic [2:0]       viol;

   logic [2:0][3:0]  bad_q, bad_d, good_q, good_d;
   logic [2:0]       flags_q, flags_d;

   logic [15:0]      hrAvg_q;
   logic [7:0]       spAvg_q;
   logic             avgValid_q, strobe_q, latched_q, fault_q;

   assign tick     = (divCnt_q == DIV_LAST);
   assign divCnt_d = tick ? '0 : divCnt_q + DIV_W'(1);
   assign noSignal = (bus.heart_rate == 16'd0) && (bus.spo2 == 8'd0);

   always_comb begin
      state_d      = state_q;
      fill_d       = fill_q;
      noSig_d      = noSig_q;
      hrWin_d      = hrWin_q;
      spWin_d      = spWin_q;
      eval_d       = 1'b0;
      enterFault_d = 1'b0;
      leaveFault_d = 1'b0;
      if (tick) begin
         if (noSignal) begin
            noSig_d = (noSig_q >= NOSIG_C) ? NOSIG_C : noSig_q + 4'd1;
            if (state_q != ST_FAULT && noSig_d >= NOSIG_C) begin
               state_d      = ST_FAULT;
               fill_d       = '0;
               hrWin_d      = '0;
               spWin_d      = '0;
               enterFault_d = 1'b1;
            end
         end else begin
            noSig_d = '0;
            hrWin_d = {hrWin_q[2:0], bus.heart_rate};
            spWin_d = {spWin_q[2:0], bus.spo2};
            case (state_q)
               ST_FILL: begin
                  fill_d = fill_q + 3'd1;
                  if (fill_q == 3'd3) begin
                     state_d = ST_RUN;
                     eval_d  = 1'b1;
                  end
               end
               ST_RUN: eval_d = 1'b1;
               default: begin
                  // Recovering sample becomes the first entry of a fresh window.
                  state_d      = ST_FILL;
                  fill_d       = 3'd1;
                  hrWin_d      = {48'd0, bus.heart_rate};
                  spWin_d      = {24'd0, bus.spo2};
                  leaveFault_d = 1'b1;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk_1MHz) begin
      if (rst_n) begin
         divCnt_q     <= '0;
         state_q      <= ST_FILL;
         fill_q       <= '0;
         noSig_q      <= '0;
         hrWin_q      <= '0;
         spWin_q      <= '0;
         eval_q       <= 1'b0;
         enterFault_q <= 1'b0;
         leaveFault_q <= 1'b0;
      end else begin
         divCnt_q     <= divCnt_d;
         state_q      <= state_d;
         fill_q       <= fill_d;
         noSig_q      <= noSig_d;
         hrWin_q      <= hrWin_d;
         spWin_q      <= spWin_d;
         eval_q       <= eval_d;
         enterFault_q <= enterFault_d;
         leaveFault_q <= leaveFault_d;
      end
   end

   assign hrSum = 18'(hrWin_q[0]) + 18'(hrWin_q[1]) + 18'(hrWin_q[2]) + 18'(hrWin_q[3]);
   assign spSum = 10'(spWin_q[0]) + 10'(spWin_q[1]) + 10'(spWin_q[2]) + 10'(spWin_q[3]);
   assign hrAvgNow = hrSum[17:2];
   assign spAvgNow = spSum[9:2];
   assign viol = {spAvgNow < SPO2_LOW, hrAvgNow < HR_LOW, hrAvgNow > HR_HIGH};

   // Each flag needs PERSIST consecutive agreeing averages before it changes.
   always_comb begin
      bad_d   = bad_q;
      good_d  = good_q;
      flags_d = flags_q;
      if (enterFault_q) begin
         bad_d   = '0;
         good_d  = '0;
         flags_d = '0;
      end else if (eval_q) begin
         for (int i = 0; i < 3; i++) begin
            if (viol[i]) begin
               good_d[i] = '0;
               bad_d[i]  = (bad_q[i] >= PERSIST_C) ? PERSIST_C : bad_q[i] + 4'd1;
               if (bad_d[i] == PERSIST_C) flags_d[i] = 1'b1;
            end else begin
               bad_d[i]  = '0;
               good_d[i] = (good_q[i] >= PERSIST_C) ? PERSIST_C : good_q[i] + 4'd1;
               if (good_d[i] == PERSIST_C) flags_d[i] = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk_1MHz) begin
      if (rst_n) begin
         bad_q      <= '0;
         good_q     <= '0;
         flags_q    <= '0;
         hrAvg_q    <= '0;
         spAvg_q    <= '0;
         avgValid_q <= 1'b0;
         strobe_q   <= 1'b0;
         latched_q  <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         bad_q    <= bad_d;
         good_q   <= good_d;
         flags_q  <= flags_d;
         strobe_q <= eval_q;
         if (eval_q) begin
            hrAvg_q    <= hrAvgNow;
            spAvg_q    <= spAvgNow;
            avgValid_q <= 1'b1;
         end
         if (enterFault_q) begin
            avgValid_q <= 1'b0;
            fault_q    <= 1'b1;
         end
         if (leaveFault_q) fault_q <= 1'b0;
         if (|flags_q) latched_q <= 1'b1;
         else if (bus.alarm_ack) latched_q <= 1'b0;
      end
   end

   assign bus.hr_avg         = hrAvg_q;
   assign bus.spo2_avg       = spAvg_q;
   assign bus.avg_valid      = avgValid_q;
   assign bus.avg_strobe     = strobe_q;
   assign bus.hr_high_alarm  = flags_q[0];
   assign bus.hr_low_alarm   = flags_q[1];
   assign bus.spo2_low_alarm = flags_q[2];
   assign bus.alarm_latched  = latched_q;
   assign bus.sensor_fault   = fault_q;

endmodule

// File: tb/tb_vital_alarm_monitor.sv
// Bench for vital_alarm_monitor: directed scenarios with literal expectations plus
// randomized segments, all outputs compared every cycle against a sample-level model.
module tb_vital_alarm_monitor;

   localparam int SDIV = 8;
   localparam int PERS = 3;
   localparam int NLIM = 5;
   localparam int HRH  = 120;
   localparam int HRL  = 40;
   localparam int SPL  = 90;

   logic clk = 1'b0;
   logic rst = 1'b1;

   vital_alarm_monitor_if bus();

   vital_alarm_monitor #(
      .SAMPLE_DIV(SDIV), .HR_HIGH(16'd120), .HR_LOW(16'd40), .SPO2_LOW(8'd90),
      .PERSIST(PERS), .NOSIG_LIMIT(NLIM)
   ) dut (
      .clk_1MHz(clk),
      .rst_n(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Model state: the list of valid samples in the window, the no-signal run length,
   // and the recent violation history of each flag.
   int   phase;
   bit   mFaulted;
   int   mRun;
   int   hrQ[$];
   int   spQ[$];
   logic [15:0] hist[3];
   int   histLen[3];
   bit   mFlag[3];
   bit   pEval, pFault, pLeave;
   int   pHr, pSp;
   bit   pFlag[3];
   int   eHr, eSp;
   bit   eValid, eStrobe, eLatched, eFault;
   bit   eFlag[3];
   bit   modelReady = 1'b0;

   function automatic void resetModel();
      phase = 0; mFaulted = 0; mRun = 0;
      hrQ.delete(); spQ.delete();
      for (int i = 0; i < 3; i++) begin
         hist[i] = '0; histLen[i] = 0; mFlag[i] = 0; pFlag[i] = 0; eFlag[i] = 0;
      end
      pEval = 0; pFault = 0; pLeave = 0; pHr = 0; pSp = 0;
      eHr = 0; eSp = 0; eValid = 0; eStrobe = 0; eLatched = 0; eFault = 0;
   endfunction

   function automatic void sampleModel(input int h, input int s);
      int sh, ss, avgH, avgS, mask;
      bit v[3];
      if (h == 0 && s == 0) begin
         mRun++;
         if (!mFaulted && mRun >= NLIM) begin
            mFaulted = 1;
            hrQ.delete(); spQ.delete();
            for (int i = 0; i < 3; i++) begin
               hist[i] = '0; histLen[i] = 0; mFlag[i] = 0;
            end
            pFault = 1;
         end
      end else begin
         mRun = 0;
         if (mFaulted) begin
            mFaulted = 0;
            hrQ = {h};
            spQ = {s};
            pLeave = 1;
         end else begin
            hrQ.push_back(h);
            spQ.push_back(s);
            if (hrQ.size() > 4) begin
               void'(hrQ.pop_front());
               void'(spQ.pop_front());
            end
            if (hrQ.size() == 4) begin
               sh = 0; ss = 0;
               foreach (hrQ[i]) sh += hrQ[i];
               foreach (spQ[i]) ss += spQ[i];
               avgH = sh / 4;
               avgS = ss / 4;
               v[0] = (avgH > HRH);
               v[1] = (avgH < HRL);
               v[2] = (avgS < SPL);
               mask = (1 << PERS) - 1;
               for (int i = 0; i < 3; i++) begin
                  hist[i] = {hist[i][14:0], v[i]};
                  if (histLen[i] < 16) histLen[i]++;
                  if (histLen[i] >= PERS) begin
                     if ((int'(hist[i]) & mask) == mask) mFlag[i] = 1;
                     else if ((int'(hist[i]) & mask) == 0) mFlag[i] = 0;
                  end
                  pFlag[i] = mFlag[i];
               end
               pEval = 1; pHr = avgH; pSp = avgS;
            end
         end
      end
   endfunction

   // Model advances on each rising edge using the inputs held during the ending cycle.
   always @(posedge clk) begin
      if (rst) begin
         resetModel();
         modelReady = 1'b1;
      end else begin
         if (eFlag[0] || eFlag[1] || eFlag[2]) eLatched = 1;
         else if (bus.alarm_ack) eLatched = 0;
         eStrobe = pEval;
         if (pEval) begin
            eHr = pHr; eSp = pSp; eValid = 1;
            for (int i = 0; i < 3; i++) eFlag[i] = pFlag[i];
         end
         if (pFault) begin
            eValid = 0; eFault = 1;
            for (int i = 0; i < 3; i++) eFlag[i] = 0;
         end
         if (pLeave) eFault = 0;
         pEval = 0; pFault = 0; pLeave = 0;
         if (phase == SDIV - 1) begin
            sampleModel(int'(bus.heart_rate), int'(bus.spo2));
            phase = 0;
         end else begin
            phase++;
         end
      end
   end

   // Every output is compared against the model on each falling edge.
   always @(negedge clk) begin
      if (modelReady) begin
         checkOutput("hr_avg", bus.hr_avg, eHr);
         checkOutput("spo2_avg", bus.spo2_avg, eSp);
         checkOutput("avg_valid", bus.avg_valid, eValid);
         checkOutput("avg_strobe", bus.avg_strobe, eStrobe);
         checkOutput("hr_high_alarm", bus.hr_high_alarm, eFlag[0]);
         checkOutput("hr_low_alarm", bus.hr_low_alarm, eFlag[1]);
         checkOutput("spo2_low_alarm", bus.spo2_low_alarm, eFlag[2]);
         checkOutput("alarm_latched", bus.alarm_latched, eLatched);
         checkOutput("sensor_fault", bus.sensor_fault, eFault);
      end
   end

   // Holds the levels for one full tick period; returns in the cycle the results appear.
   task automatic applyStimulus(input int h, input int s);
      bus.heart_rate = 16'(h);
      bus.spo2       = 8'(s);
      repeat (SDIV) @(negedge clk);
   endtask

   task automatic doReset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checkOutput("rst_hr_avg", bus.hr_avg, 0);
      checkOutput("rst_spo2_avg", bus.spo2_avg, 0);
      checkOutput("rst_avg_valid", bus.avg_valid, 0);
      checkOutput("rst_strobe", bus.avg_strobe, 0);
      checkOutput("rst_flags", {bus.hr_high_alarm, bus.hr_low_alarm, bus.spo2_low_alarm}, 0);
      checkOutput("rst_latched", bus.alarm_latched, 0);
      checkOutput("rst_fault", bus.sensor_fault, 0);
      @(negedge clk);
   endtask

   initial begin
      int bnd[6];
      int mode, nTicks, h, s;
      bnd = '{39, 40, 41, 119, 120, 121};
      bus.heart_rate = '0;
      bus.spo2       = '0;
      bus.alarm_ack  = 1'b0;
      @(negedge clk);
      doReset();

      repeat (3) applyStimulus(75, 98);
      checkOutput("fill_not_valid", bus.avg_valid, 0);
      applyStimulus(75, 98);
      checkOutput("first_strobe", bus.avg_strobe, 1);
      checkOutput("first_hr_avg", bus.hr_avg, 75);
      checkOutput("first_spo2_avg", bus.spo2_avg, 98);
      checkOutput("first_valid", bus.avg_valid, 1);

      applyStimulus(60, 98);
      applyStimulus(61, 98);
      applyStimulus(62, 98);
      applyStimulus(64, 98);
      checkOutput("win_avg_247", bus.hr_avg, 61);
      applyStimulus(70, 98);
      checkOutput("win_avg_257", bus.hr_avg, 64);

      repeat (5) applyStimulus(130, 98);
      checkOutput("hr_high_2nd_viol", bus.hr_high_alarm, 0);
      applyStimulus(130, 98);
      checkOutput("hr_high_3rd_viol", bus.hr_high_alarm, 1);
      repeat (2) applyStimulus(80, 98);
      checkOutput("hr_high_2nd_norm", bus.hr_high_alarm, 1);
      applyStimulus(80, 98);
      checkOutput("hr_high_3rd_norm", bus.hr_high_alarm, 0);
      checkOutput("latched_after_hr", bus.alarm_latched, 1);

      repeat (7) applyStimulus(120, 98);
      checkOutput("hr_eq_thresh_avg", bus.hr_avg, 120);
      checkOutput("hr_eq_thresh_flag", bus.hr_high_alarm, 0);
      bus.alarm_ack = 1'b1;
      applyStimulus(120, 98);
      bus.alarm_ack = 1'b0;
      checkOutput("ack_clears", bus.alarm_latched, 0);

      repeat (4) applyStimulus(120, 85);
      checkOutput("spo2_low_2nd", bus.spo2_low_alarm, 0);
      applyStimulus(120, 85);
      checkOutput("spo2_low_3rd", bus.spo2_low_alarm, 1);
      checkOutput("spo2_avg_85", bus.spo2_avg, 85);
      bus.alarm_ack = 1'b1;
      applyStimulus(120, 85);
      bus.alarm_ack = 1'b0;
      checkOutput("ack_while_active", bus.alarm_latched, 1);
      repeat (3) applyStimulus(120, 98);
      checkOutput("spo2_still_set", bus.spo2_low_alarm, 1);
      applyStimulus(120, 98);
      checkOutput("spo2_cleared", bus.spo2_low_alarm, 0);
      bus.alarm_ack = 1'b1;
      applyStimulus(120, 98);
      bus.alarm_ack = 1'b0;
      checkOutput("ack_after_clear", bus.alarm_latched, 0);

      repeat (6) applyStimulus(30, 98);
      checkOutput("hr_low_set", bus.hr_low_alarm, 1);
      repeat (4) applyStimulus(0, 0);
      checkOutput("nosig4_fault", bus.sensor_fault, 0);
      checkOutput("nosig4_valid", bus.avg_valid, 1);
      applyStimulus(0, 0);
      checkOutput("nosig5_fault", bus.sensor_fault, 1);
      checkOutput("nosig5_valid", bus.avg_valid, 0);
      checkOutput("nosig5_hr_low", bus.hr_low_alarm, 0);
      checkOutput("nosig5_latched", bus.alarm_latched, 1);
      applyStimulus(72, 97);
      checkOutput("recover_fault", bus.sensor_fault, 0);
      checkOutput("recover_not_valid", bus.avg_valid, 0);
      repeat (3) applyStimulus(72, 97);
      checkOutput("recover_valid", bus.avg_valid, 1);
      checkOutput("recover_hr_avg", bus.hr_avg, 72);
      checkOutput("recover_spo2_avg", bus.spo2_avg, 97);

      repeat (6) @(negedge clk);
      doReset();
      checkOutput("post_reset_strobe", bus.avg_strobe, 0);
      repeat (3) applyStimulus(75, 98);
      checkOutput("refill_not_valid", bus.avg_valid, 0);
      applyStimulus(75, 98);
      checkOutput("refill_valid", bus.avg_valid, 1);
      checkOutput("refill_hr_avg", bus.hr_avg, 75);

      for (int seg = 0; seg < 120; seg++) begin
         mode = $urandom_range(0, 9);
         if (mode < 2) begin
            h = 0; s = 0; nTicks = $urandom_range(3, 7);
         end else if (mode == 2) begin
            h = 0; s = $urandom_range(1, 100); nTicks = $urandom_range(1, 3);
         end else if (mode == 3) begin
            h = bnd[$urandom_range(0, 5)]; s = $urandom_range(88, 92); nTicks = $urandom_range(2, 6);
         end else begin
            h = $urandom_range(20, 150); s = $urandom_range(80, 100); nTicks = $urandom_range(1, 6);
         end
         bus.heart_rate = 16'(h);
         bus.spo2       = 8'(s);
         for (int c = 0; c < nTicks * SDIV; c++) begin
            bus.alarm_ack = ($urandom_range(0, 15) == 0);
            rst           = ($urandom_range(0, 499) == 0);
            @(negedge clk);
         end
      end
      rst           = 1'b0;
      bus.alarm_ack = 1'b0;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vital_alarm_monitor.md
# vital_alarm_monitor

Downstream consumer of the MAX30100 vital-sign path. Samples the free-running `heart_rate` and `spo2` outputs on a fixed tick, smooths them with a 4-sample moving average, and raises persistence-filtered threshold alarms, a latched alarm for the operator panel, and a sensor-fault flag when the sensor reports no signal. Sits between the MAX30100 system block and the top-level status/display logic.

## Interface
- `SAMPLE_DIV`, 1000000, clock cycles between sample ticks (1 s at 1 MHz); ≥2
- `HR_HIGH`, 16'd120, heart-rate high threshold (BPM), strict `>`
- `HR_LOW`, 16'd40, heart-rate low threshold (BPM), strict `<`; HR_LOW < HR_HIGH
- `SPO2_LOW`, 8'd90, SpO₂ low threshold (%), strict `<`
- `PERSIST`, 3, consecutive averaged samples needed to set or clear a flag; 1–15
- `NOSIG_LIMIT`, 5, consecutive no-signal samples before `sensor_fault`; 1–15
- `clk_1MHz`  in  1  system clock
- `rst_n`  in  1  reset; **synchronous, active-high** (asserted = 1)
- `heart_rate`  in  16  BPM from MAX30100 system, unqualified level
- `spo2`  in  8  SpO₂ % from MAX30100 system, unqualified level
- `alarm_ack`  in  1  operator acknowledge, level or pulse
- `hr_avg`  out  16  averaged heart rate
- `spo2_avg`  out  8  averaged SpO₂
- `avg_valid`  out  1  window full, averages meaningful
- `avg_strobe`  out  1  one-cycle pulse when averages/flags update
- `hr_high_alarm`, `hr_low_alarm`, `spo2_low_alarm`  out  1 each  filtered alarm flags
- `alarm_latched`  out  1  sticky any-alarm indicator
- `sensor_fault`  out  1  no-signal fault

## Operation
- Tick divider: counter 0..SAMPLE_DIV-1; `tick` internal, high when counter == SAMPLE_DIV-1; counter wraps to 0.
- On tick: sample is "no-signal" if `heart_rate == 0 && spo2 == 0`, else "valid".
- FSM states: FILL, RUN, FAULT. Reset → FILL, fill count 0.
- FILL: each valid sample shifts into 4-entry window (HR and SpO₂), fill count++. On 4th sample → RUN.
- RUN: each valid sample shifts into window, oldest dropped.
- No-signal counter: increments (saturating) on no-signal sample, clears on valid sample. No-signal samples are not written to the window. When count reaches NOSIG_LIMIT from FILL or RUN → FAULT.
- Entering FAULT: window and fill count cleared, `avg_valid`=0, three alarm flags and persistence counters cleared, `sensor_fault`=1. `alarm_latched` unchanged.
- FAULT: first valid sample → FILL with that sample as entry 1, `sensor_fault`=0.
- Arithmetic: HR sum 18 bits, SpO₂ sum 10 bits, sum of the 4 window entries; avg = sum >> 2 (truncate). No overflow possible.
- Averages/flags evaluated only in RUN (including the sample that completes FILL).
- Persistence per flag: violating average → bad count++ (saturate at PERSIST), good count = 0; flag sets when bad count reaches PERSIST. Normal average → good count++, bad count = 0; flag clears when good count reaches PERSIST. Average equal to threshold is normal.
- `alarm_latched`: set on any cycle any flag is 1; cleared by `alarm_ack` only when all three flags are 0. Set and ack in same cycle → set wins.

## Timing
- Reset (sync, `rst_n`=1 at clock edge): all outputs 0, divider 0, FSM FILL, all counters 0.
- Tick at cycle T: window/FSM/no-signal counter update at edge ending T.
- `hr_avg`, `spo2_avg`, `avg_valid`, alarm flags, `sensor_fault` update at edge ending T+1; `avg_strobe` high during T+2 only, and only when a RUN evaluation occurred.
- `alarm_latched` follows flags one cycle later; ack effect visible the cycle after the ack edge.
- Outputs hold between strobes. Reset mid-tick discards the in-flight sample.
- No handshake on inputs; values are sampled only on tick edges.

## Test plan
- SAMPLE_DIV=8: constant HR=75, SpO₂=98 → first `avg_strobe` after 4th tick; `hr_avg`=75, `spo2_avg`=98, `avg_valid`=1, no alarms.
- Window math: HR sequence 60,61,62,64 → `hr_avg`=61 (247>>2); next 70 → 64 (257>>2).
- Persistence PERSIST=3: averaged HR steps to 130 → `hr_high_alarm` sets on 3rd violating strobe, not 2nd; back to 80 → clears on 3rd normal strobe; HR=120 exactly never alarms.
- Latch: SpO₂ avg 85 sets `spo2_low_alarm` and `alarm_latched`; `alarm_ack` while active → stays 1; after flag clears, ack → `alarm_latched`=0 next cycle.
- Fault: 5 ticks with HR=0, SpO₂=0 → `sensor_fault`=1, `avg_valid`=0, flags 0; then HR=72/SpO₂=97 → `sensor_fault`=0, averages valid again 4 valid ticks later.
- Reset mid-run: assert `rst_n` one cycle during tick cycle → all outputs 0 next edge, FILL restarts, no spurious strobe.
